// File: rtl/array_ext_pkg.sv
// Shared types and helpers for the parametrised single-port array with lane masking.
package array_ext_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Bitwise merge: a bit whose lane is enabled takes the new value, otherwise keeps the old one.
  function automatic logic lane_merge(input logic old_val, input logic new_val, input logic mask);
    logic res;
    if (mask) begin
      res = new_val;
    end else begin
      res = old_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/array_init_seq.sv
// Post-reset zero-fill sequencer: sweeps every word address once, then raises ready.
module array_init_seq
  import array_ext_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int DEPTH         = 4096,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic              ready_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam init_state_e       RESET_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

  init_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  // State, sweep counter and registered ready flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= {ADDR_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = INIT;
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        state_d = RUN;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
    ready_d = (state_d == RUN);
  end

  always_comb begin
    init_we_o   = (state_q == INIT);
    init_addr_o = cnt_q;
    ready_o     = ready_q;
  end

endmodule

// File: rtl/array_rw_mask_ext.sv
// Single-port synchronous array with per-lane write mask, 1/2-cycle read latency
// and an optional zero-fill sweep after reset.
module array_rw_mask_ext
  import array_ext_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int DEPTH         = 4096,
  parameter int LANES         = 1,
  parameter int LANE_W        = 15,
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                      RW0_clk,
  input  logic                      RW0_reset,
  input  logic [ADDR_W-1:0]         RW0_addr,
  input  logic                      RW0_en,
  input  logic                      RW0_wmode,
  input  logic [LANES-1:0]          RW0_wmask,
  input  logic [LANES*LANE_W-1:0]   RW0_wdata,
  output logic [LANES*LANE_W-1:0]   RW0_rdata,
  output logic                      RW0_rvalid,
  output logic                      RW0_ready
);

  localparam int DW = LANES * LANE_W;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("array_rw_mask_ext: RD_LAT must be 1 or 2");
  end
  if (DEPTH > (32'sd2 ** ADDR_W)) begin : g_bad_depth
    $error("array_rw_mask_ext: DEPTH exceeds the address space");
  end

  logic              init_we_s;
  logic [ADDR_W-1:0] init_addr_s;
  logic              ready_s;

  array_init_seq #(
    .ADDR_W        (ADDR_W),
    .DEPTH         (DEPTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_seq (
    .clk_i       (RW0_clk),
    .rst_i       (RW0_reset),
    .init_we_o   (init_we_s),
    .init_addr_o (init_addr_s),
    .ready_o     (ready_s)
  );

  assign RW0_ready = ready_s;

  logic accept_s;
  logic in_range_s;

  assign accept_s   = RW0_en & ready_s;
  assign in_range_s = ({1'b0, RW0_addr} < (ADDR_W + 1)'(DEPTH));

  logic [DW-1:0]     mem_q [DEPTH];
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DW-1:0]     wr_data_s;
  logic [LANES-1:0]  wr_mask_s;
  logic [DW-1:0]     old_word_s;
  logic [DW-1:0]     merged_s;

  // The sweep owns the write port while it runs; user writes need ready and an in-range address.
  always_comb begin
    if (init_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = init_addr_s;
      wr_data_s   = {DW{1'b0}};
      wr_mask_s   = {LANES{1'b1}};
    end else begin
      mem_we_s    = accept_s & RW0_wmode & in_range_s;
      mem_waddr_s = RW0_addr;
      wr_data_s   = RW0_wdata;
      wr_mask_s   = RW0_wmask;
    end
  end

  always_comb begin
    old_word_s = mem_q[mem_waddr_s];
    merged_s   = old_word_s;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < LANE_W; b++) begin
        merged_s[l*LANE_W+b] = lane_merge(old_word_s[l*LANE_W+b], wr_data_s[l*LANE_W+b], wr_mask_s[l]);
      end
    end
  end

  // Storage is intentionally not reset; the sweep provides defined contents.
  always_ff @(posedge RW0_clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= merged_s;
    end
  end

  logic              rd_pend_q;
  logic              rd_oob_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DW-1:0]     rd_word_s;

  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) begin
      rd_pend_q <= 1'b0;
      rd_oob_q  <= 1'b0;
      rd_addr_q <= {ADDR_W{1'b0}};
    end else begin
      rd_pend_q <= accept_s & ~RW0_wmode;
      if (accept_s & ~RW0_wmode) begin
        rd_addr_q <= RW0_addr;
        rd_oob_q  <= ~in_range_s;
      end
    end
  end

  assign rd_word_s = rd_oob_q ? {DW{1'b0}} : mem_q[rd_addr_q];

  logic          s1_valid_q;
  logic [DW-1:0] s1_data_q;

  // Array read stage; data holds until the next read lands.
  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {DW{1'b0}};
    end else begin
      s1_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        s1_data_q <= rd_word_s;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          s2_valid_q;
    logic [DW-1:0] s2_data_q;

    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
      if (RW0_reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= {DW{1'b0}};
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign RW0_rvalid = s2_valid_q;
    assign RW0_rdata  = s2_data_q;
  end else begin : g_lat1
    assign RW0_rvalid = s1_valid_q;
    assign RW0_rdata  = s1_data_q;
  end

endmodule

// File: doc/array_rw_mask_ext.md
# array_rw_mask_ext

Parametrised single-port synchronous SRAM model, successor to the fixed 4096×15 array macros. It adds per-lane write masking, a selectable 1- or 2-cycle read latency with a valid strobe, and an optional zero-fill sweep after reset with a ready flag. It sits behind generated `*_ext` memory wrappers in cache and predictor arrays. It is simulation/FPGA behavioural RTL.

## Interface

**Parameters**
- `ADDR_W`, 12: address width.
- `DEPTH`, 4096: number of words; must satisfy DEPTH ≤ 2^ADDR_W.
- `LANES`, 1: number of independently maskable lanes per word.
- `LANE_W`, 15: bits per lane; word width is `DW = LANES*LANE_W`.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 and 2.
- `INIT_ON_RESET`, 1: when 1, zero-fill the array after reset.

**Ports**
- `RW0_clk`, in, 1: clock.
- `RW0_reset`, in, 1: **one clock; reset is asynchronous and active-high.**
- `RW0_addr`, in, ADDR_W: word address.
- `RW0_en`, in, 1: request strobe.
- `RW0_wmode`, in, 1: 1 = write, 0 = read.
- `RW0_wmask`, in, LANES: per-lane write enable.
- `RW0_wdata`, in, DW: write data; lane i occupies `[i*LANE_W +: LANE_W]`.
- `RW0_rdata`, out, DW: read data.
- `RW0_rvalid`, out, 1: single-cycle strobe marking fresh `RW0_rdata`.
- `RW0_ready`, out, 1: array accepts requests.

## Operation

- **Request acceptance.** A request is accepted on a rising edge when `RW0_en && RW0_ready`. Requests made while `RW0_ready` is 0 are dropped silently. Nothing is queued.
- **Write.** An accepted request with `wmode=1` updates each lane i where `wmask[i]=1`. Unmasked lanes keep their value. A write with `wmask=0` is a no-op. A write produces no `rvalid`.
- **Read.** An accepted request with `wmode=0` captures the address. The data appears after RD_LAT cycles, together with a one-cycle `rvalid`.
- **Data hold.** `RW0_rdata` holds the last read value until the next read returns. It never shows garbage or random data.
- **Out-of-range addresses.** If `addr ≥ DEPTH`, a write is ignored. A read returns 0 but still asserts `rvalid`.
- **Reset values.** All outputs reset to 0: `rdata=0`, `rvalid=0`, `ready=0`. The array contents are not reset.
- **Init FSM**, states INIT and RUN:
  - In reset the FSM is in INIT with the sweep counter at 0.
  - In INIT, one zero word is written per cycle at addresses 0..DEPTH-1.
  - After writing DEPTH-1 the FSM moves to RUN and `ready` rises.
  - With `INIT_ON_RESET=0`, reset lands in RUN and `ready` is 0 only while reset is asserted.
- **Reset during the sweep or a pending read.** The counter restarts at 0 and any in-flight `rvalid` is cancelled. `rdata` returns to 0.

## Timing

- **Reset release.** Reset deasserts before edge E0.
  - With `INIT_ON_RESET=1`: edges E0..E(DEPTH-1) zero addresses 0..DEPTH-1, and `ready`=1 after edge E(DEPTH-1), i.e. for DEPTH=4096, `ready` is high from cycle 4096 onward.
  - With `INIT_ON_RESET=0`: `ready`=1 after edge E0.
- **Read, RD_LAT=1.** Read accepted at edge N → `rdata` and `rvalid` valid after edge N+1.
- **Read, RD_LAT=2.** Read accepted at edge N → valid after edge N+2. The extra stage is an output register on the data.
- **Throughput.** One request per cycle. Back-to-back reads give back-to-back `rvalid` pulses.
- **Write then read.** A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- **Read then write.** A read at edge N followed by a write of the same address at edge N+1:
  - RD_LAT=1 returns the old data.
  - RD_LAT=2 also returns the old data, because the array is read at edge N+1 before the write lands.

## Structure

- Package `array_ext_pkg`:
  - init state enum {INIT, RUN};
  - `RD_LAT_MIN=1`, `RD_LAT_MAX=2`;
  - function `lane_merge(old, new, mask)`.
- Sub-module `array_init_seq`:
  - contains the INIT/RUN FSM and the ADDR_W-bit sweep counter;
  - outputs `init_we`, `init_addr`, `ready`.
- The top level muxes init writes against user writes and holds the array plus the read pipeline.
- An elaboration-time check rejects `RD_LAT ∉ {1,2}` and `DEPTH > 2^ADDR_W`.

## Test plan

Configuration for all cases: DEPTH=4096, LANES=3, LANE_W=5, INIT_ON_RESET=1 unless stated.

1. **Init sweep.** Release reset → `ready`=0 for 4096 cycles, then 1. A read of address 4095 returns 0 with `rvalid` at +RD_LAT.
2. **Masked write.** Write `wdata=0x7FFF`, `wmask=3'b111` to address 5. Then write `wdata=0x0000`, `wmask=3'b010` to address 5. Read address 5 → `0x7C1F`.
3. **Latency.** With RD_LAT=2, back-to-back reads of addresses 1, 2, 3 holding 0x11, 0x22, 0x33 → `rvalid` on three consecutive cycles starting 2 cycles after the first read, with `rdata` 0x11, 0x22, 0x33. `rdata` then holds 0x33.
4. **Early request dropped.** A write of 0x1234 to address 7 issued during INIT is dropped. After `ready`, a read of address 7 → 0.
5. **Reset mid-sweep and mid-read.**
   - Assert reset at sweep cycle 100: `ready` stays 0 and the sweep restarts from 0.
   - Assert reset one cycle after a read is accepted: no `rvalid`, and `rdata`=0.
6. **No-init configuration and edge addresses.** With INIT_ON_RESET=0, `ready`=1 one edge after reset release. Write 0x0ABC to address 0 and read it back next cycle → 0x0ABC.
